// File: rtl/mlp_trainer_pkg.sv
// Shared types and scoring helpers for the MLP training sequencer.
package mlp_trainer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_SAMPLE,
    ST_UPDATE,
    ST_EPOCH_END,
    ST_FINISH
  } trainer_state_t;

  // Keeps ln() finite when the prediction saturates at exactly 0.0 or 1.0.
  localparam real EPSILON = 1.0e-7;

  // Prediction/target level that separates class 0 from class 1.
  localparam real DECISION_THRESHOLD = 0.5;

  // Binary cross-entropy contribution of one output.
  function automatic real bce_term(input real y, input real p);
    return -(y * $ln(p + EPSILON) + (1.0 - y) * $ln(1.0 - p + EPSILON));
  endfunction

  // An output is classified correctly when prediction and target fall on the same side.
  function automatic logic is_correct(input real y, input real p);
    return (p >= DECISION_THRESHOLD) == (y >= DECISION_THRESHOLD);
  endfunction

endpackage

// File: rtl/trainer_sample_mem.sv
// Training-set register file: one write port, one combinational read port.
module trainer_sample_mem #(
  parameter int INPUTS      = 2,
  parameter int OUTPUTS     = 1,
  parameter int NUM_SAMPLES = 4,
  parameter int AW          = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  real           wvalues_i   [INPUTS],
  input  real           wexpected_i [OUTPUTS],
  input  logic [AW-1:0] raddr_i,
  output real           rvalues_o   [INPUTS],
  output real           rexpected_o [OUTPUTS]
);

  real values_q   [NUM_SAMPLES][INPUTS];
  real expected_q [NUM_SAMPLES][OUTPUTS];

  // Clear the whole set on reset; otherwise store one sample per write strobe.
  // NOTE: this storage is a small flop array, so it is cleared on reset like any
  // other state; a RAM macro would have no reset and need an explicit clear pass.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < NUM_SAMPLES; s++) begin
        for (int i = 0; i < INPUTS; i++)  values_q[s][i]   <= 0.0;
        for (int o = 0; o < OUTPUTS; o++) expected_q[s][o] <= 0.0;
      end
    end else if (we_i) begin
      for (int i = 0; i < INPUTS; i++)  values_q[waddr_i][i]   <= wvalues_i[i];
      for (int o = 0; o < OUTPUTS; o++) expected_q[waddr_i][o] <= wexpected_i[o];
    end
  end

  // Combinational read of the addressed sample.
  always_comb begin
    for (int i = 0; i < INPUTS; i++)  rvalues_o[i]   = values_q[raddr_i][i];
    for (int o = 0; o < OUTPUTS; o++) rexpected_o[o] = expected_q[raddr_i][o];
  end

endmodule

// File: rtl/mlp_trainer.sv
// Presents stored samples to an MLP, scores its predictions per epoch and stops
// on convergence, on the epoch limit, or after one epoch in evaluation mode.
module mlp_trainer
  import mlp_trainer_pkg::*;
#(
  parameter int  INPUTS        = 2,
  parameter int  OUTPUTS       = 1,
  parameter int  NUM_SAMPLES   = 4,
  parameter int  MAX_EPOCHS    = 1000,
  parameter int  SETTLE_CYCLES = 2,
  localparam int AW = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1,
  localparam int CW = $clog2(NUM_SAMPLES + 1),
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          eval_only,
  input  real           learning_rate_in,
  input  real           loss_threshold,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  real           wr_values   [INPUTS],
  input  real           wr_expected [OUTPUTS],
  output real           mlp_values  [INPUTS],
  output real           mlp_expected[OUTPUTS],
  output logic          mlp_training,
  output real           mlp_learning_rate,
  input  real           mlp_prediction [OUTPUTS],
  output logic          busy,
  output logic          done,
  output logic          converged,
  output logic [31:0]   epoch_count,
  output real           epoch_loss,
  output logic [CW-1:0] correct_count
);

  trainer_state_t state_q, state_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic [SW-1:0]  settle_q, settle_d;
  logic           eval_q, eval_d;
  real            lr_q, lr_d;
  real            thr_q, thr_d;
  real            loss_acc_q, loss_acc_d;
  logic [CW-1:0]  corr_acc_q, corr_acc_d;
  logic [31:0]    epoch_count_q, epoch_count_d;
  real            epoch_loss_q, epoch_loss_d;
  logic [CW-1:0]  correct_count_q, correct_count_d;
  logic           converged_q, converged_d;
  real            values_q   [INPUTS];
  real            values_d   [INPUTS];
  real            expected_q [OUTPUTS];
  real            expected_d [OUTPUTS];

  real            rd_values   [INPUTS];
  real            rd_expected [OUTPUTS];
  logic           mem_we;
  logic           last_sample;
  real            loss_term;
  logic           all_ok;
  real            new_loss;
  logic [31:0]    new_epochs;

  // The set may only change between runs, and only at addresses that exist.
  assign mem_we      = wr_en && (state_q == ST_IDLE) && (int'(wr_addr) < NUM_SAMPLES);
  assign last_sample = (idx_q == AW'(NUM_SAMPLES - 1));

  trainer_sample_mem #(
    .INPUTS      (INPUTS),
    .OUTPUTS     (OUTPUTS),
    .NUM_SAMPLES (NUM_SAMPLES),
    .AW          (AW)
  ) u_mem (
    .clk         (clk),
    .rst         (rst),
    .we_i        (mem_we),
    .waddr_i     (wr_addr),
    .wvalues_i   (wr_values),
    .wexpected_i (wr_expected),
    .raddr_i     (idx_q),
    .rvalues_o   (rd_values),
    .rexpected_o (rd_expected)
  );

  // Next-state and datapath updates for the run sequencer.
  // NOTE: combinational blocks use blocking '=' with every target defaulted first,
  // so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    settle_d        = settle_q;
    eval_d          = eval_q;
    lr_d            = lr_q;
    thr_d           = thr_q;
    loss_acc_d      = loss_acc_q;
    corr_acc_d      = corr_acc_q;
    epoch_count_d   = epoch_count_q;
    epoch_loss_d    = epoch_loss_q;
    correct_count_d = correct_count_q;
    converged_d     = converged_q;
    for (int i = 0; i < INPUTS; i++)  values_d[i]   = values_q[i];
    for (int o = 0; o < OUTPUTS; o++) expected_d[o] = expected_q[o];
    loss_term  = 0.0;
    all_ok     = 1'b1;
    new_loss   = 0.0;
    new_epochs = epoch_count_q + 32'd1;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          eval_d        = eval_only;
          lr_d          = learning_rate_in;
          thr_d         = loss_threshold;
          epoch_count_d = '0;
          loss_acc_d    = 0.0;
          corr_acc_d    = '0;
          converged_d   = 1'b0;
          idx_d         = '0;
          state_d       = ST_LOAD;
        end
      end
      ST_LOAD: begin
        for (int i = 0; i < INPUTS; i++)  values_d[i]   = rd_values[i];
        for (int o = 0; o < OUTPUTS; o++) expected_d[o] = rd_expected[o];
        settle_d = SW'(SETTLE_CYCLES - 1);
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == '0) state_d = ST_SAMPLE;
        else                settle_d = settle_q - SW'(1);
      end
      ST_SAMPLE: begin
        for (int o = 0; o < OUTPUTS; o++) begin
          loss_term = loss_term + bce_term(expected_q[o], mlp_prediction[o]);
          if (!is_correct(expected_q[o], mlp_prediction[o])) all_ok = 1'b0;
        end
        loss_acc_d = loss_acc_q + loss_term;
        if (all_ok) corr_acc_d = corr_acc_q + CW'(1);
        if (!eval_q)          state_d = ST_UPDATE;
        else if (last_sample) state_d = ST_EPOCH_END;
        else begin
          idx_d   = idx_q + AW'(1);
          state_d = ST_LOAD;
        end
      end
      ST_UPDATE: begin
        if (last_sample) state_d = ST_EPOCH_END;
        else begin
          idx_d   = idx_q + AW'(1);
          state_d = ST_LOAD;
        end
      end
      ST_EPOCH_END: begin
        new_loss        = loss_acc_q / real'(NUM_SAMPLES);
        epoch_loss_d    = new_loss;
        correct_count_d = corr_acc_q;
        epoch_count_d   = new_epochs;
        loss_acc_d      = 0.0;
        corr_acc_d      = '0;
        idx_d           = '0;
        if (eval_q) begin
          converged_d = 1'b0;
          state_d     = ST_FINISH;
        end else if (new_loss < thr_q) begin
          converged_d = 1'b1;
          state_d     = ST_FINISH;
        end else if (new_epochs == 32'(MAX_EPOCHS)) begin
          converged_d = 1'b0;
          state_d     = ST_FINISH;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any run without a done pulse.
  // NOTE: sequential blocks use non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      idx_q           <= '0;
      settle_q        <= '0;
      eval_q          <= 1'b0;
      lr_q            <= 0.0;
      thr_q           <= 0.0;
      loss_acc_q      <= 0.0;
      corr_acc_q      <= '0;
      epoch_count_q   <= '0;
      epoch_loss_q    <= 0.0;
      correct_count_q <= '0;
      converged_q     <= 1'b0;
      for (int i = 0; i < INPUTS; i++)  values_q[i]   <= 0.0;
      for (int o = 0; o < OUTPUTS; o++) expected_q[o] <= 0.0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      settle_q        <= settle_d;
      eval_q          <= eval_d;
      lr_q            <= lr_d;
      thr_q           <= thr_d;
      loss_acc_q      <= loss_acc_d;
      corr_acc_q      <= corr_acc_d;
      epoch_count_q   <= epoch_count_d;
      epoch_loss_q    <= epoch_loss_d;
      correct_count_q <= correct_count_d;
      converged_q     <= converged_d;
      for (int i = 0; i < INPUTS; i++)  values_q[i]   <= values_d[i];
      for (int o = 0; o < OUTPUTS; o++) expected_q[o] <= expected_d[o];
    end
  end

  // Status and MLP-facing outputs decoded from state and registers.
  always_comb begin
    busy              = (state_q != ST_IDLE);
    done              = (state_q == ST_FINISH);
    mlp_training      = (state_q == ST_UPDATE);
    mlp_learning_rate = (state_q != ST_IDLE) ? lr_q : 0.0;
    converged         = converged_q;
    epoch_count       = epoch_count_q;
    epoch_loss        = epoch_loss_q;
    correct_count     = correct_count_q;
    for (int i = 0; i < INPUTS; i++)  mlp_values[i]   = values_q[i];
    for (int o = 0; o < OUTPUTS; o++) mlp_expected[o] = expected_q[o];
  end

endmodule

// File: tb/tb_mlp_trainer.sv
// Directed bench for mlp_trainer driving a stub MLP whose prediction is chosen per run.
module tb_mlp_trainer;

  localparam int    NS   = 4;
  localparam int    SC   = 2;
  localparam int    MAXE = 3;
  localparam real   EPS  = 1.0e-7;
  localparam real   TOL  = 1.0e-6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       eval_only = 1'b0;
  real        learning_rate_in = 0.0;
  real        loss_threshold = 0.0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_addr = '0;
  real        wr_values [2];
  real        wr_expected [1];
  real        mlp_values [2];
  real        mlp_expected [1];
  logic       mlp_training;
  real        mlp_learning_rate;
  real        mlp_prediction [1];
  logic       busy;
  logic       done;
  logic       converged;
  logic [31:0] epoch_count;
  real        epoch_loss;
  logic [2:0] correct_count;

  int total = 0;
  int bad = 0;

  mlp_trainer #(
    .INPUTS(2), .OUTPUTS(1), .NUM_SAMPLES(NS), .MAX_EPOCHS(MAXE), .SETTLE_CYCLES(SC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .eval_only(eval_only),
    .learning_rate_in(learning_rate_in), .loss_threshold(loss_threshold),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_values(wr_values), .wr_expected(wr_expected),
    .mlp_values(mlp_values), .mlp_expected(mlp_expected), .mlp_training(mlp_training),
    .mlp_learning_rate(mlp_learning_rate), .mlp_prediction(mlp_prediction),
    .busy(busy), .done(done), .converged(converged), .epoch_count(epoch_count),
    .epoch_loss(epoch_loss), .correct_count(correct_count)
  );

  always #5 clk = ~clk;

  // Stub MLP: 0 = constant 0.5, 1 = echo target, 2 = echo target but invert on input (1,1).
  int stub_mode = 0;
  always_comb begin
    if (stub_mode == 0) mlp_prediction[0] = 0.5;
    else if (stub_mode == 2 && mlp_values[0] == 1.0 && mlp_values[1] == 1.0)
      mlp_prediction[0] = 1.0 - mlp_expected[0];
    else mlp_prediction[0] = mlp_expected[0];
  end

  // Edge monitor: cycle count, start acceptance, done and training pulses.
  int cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0, train_cnt = 0;
  always @(posedge clk) begin
    cyc++;
    if (start && !busy && rst) start_cyc = cyc;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (mlp_training) train_cnt++;
  end

  typedef struct { real v0; real v1; real y; } sample_t;
  typedef struct { string tag; int ec; int conv; int cc; int pulses; real loss; } run_exp_t;
  sample_t  rb_q[$];
  run_exp_t run_q[$];
  sample_t  xor_set [NS];
  int base_train = 0, base_done = 0;

  task automatic check(input string tag, input longint obs, input longint expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_real(input string tag, input real obs, input real expv);
    total++;
    assert ((obs - expv) < TOL && (expv - obs) < TOL) else begin
      bad++;
      $error("FAIL %s: observed=%f expected=%f", tag, obs, expv);
    end
  endtask

  task automatic write_sample(input int addr, input real v0, input real v1, input real y);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 2'(addr);
    wr_values[0] = v0; wr_values[1] = v1; wr_expected[0] = y;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Returns just after the edge that accepts start.
  task automatic start_run(input logic eo, input real lr, input real thr, input int mode);
    @(negedge clk);
    stub_mode = mode;
    eval_only = eo; learning_rate_in = lr; loss_threshold = thr;
    base_train = train_cnt; base_done = done_cnt;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic finish_run();
    int n;
    run_exp_t e;
    n = 0;
    while (!done && n < 500) begin @(negedge clk); n++; end
    check("done_seen", done, 1);
    e = run_q.pop_front();
    check({e.tag, "_epoch_count"}, epoch_count, e.ec);
    check({e.tag, "_converged"}, converged, e.conv);
    check({e.tag, "_correct"}, correct_count, e.cc);
    check_real({e.tag, "_loss"}, epoch_loss, e.loss);
    @(negedge clk);
    check({e.tag, "_done_one_cycle"}, done, 0);
    check({e.tag, "_busy_after"}, busy, 0);
    check({e.tag, "_train_pulses"}, train_cnt - base_train, e.pulses);
    check({e.tag, "_done_pulses"}, done_cnt - base_done, 1);
  endtask

  initial begin
    automatic real l_half = -$ln(0.5 + EPS);
    automatic real l_hit  = -$ln(1.0 + EPS);
    automatic real l_miss = -$ln(EPS);
    automatic sample_t s;
    int n;

    xor_set[0] = '{0.0, 0.0, 0.0};
    xor_set[1] = '{0.0, 1.0, 1.0};
    xor_set[2] = '{1.0, 0.0, 1.0};
    xor_set[3] = '{1.0, 1.0, 0.0};
    wr_values[0] = 0.0; wr_values[1] = 0.0; wr_expected[0] = 0.0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_training", mlp_training, 0);
    check("rst_epoch_count", epoch_count, 0);
    check_real("rst_lr", mlp_learning_rate, 0.0);
    rst = 1'b1;

    // Load XOR set; each written sample becomes a read-back expectation.
    for (int k = 0; k < NS; k++) begin
      write_sample(k, xor_set[k].v0, xor_set[k].v1, xor_set[k].y);
      rb_q.push_back(xor_set[k]);
    end

    // Eval read-back: samples in index order, each held 1+SC+1 cycles.
    run_q.push_back('{"eval_rb", 1, 0, 4, 0, l_hit});
    start_run(1'b1, 0.3, 10.0, 1);
    for (int k = 0; k < NS; k++) begin
      s = rb_q.pop_front();
      @(posedge clk);
      @(negedge clk);
      check_real($sformatf("rb%0d_v0", k), mlp_values[0], s.v0);
      check_real($sformatf("rb%0d_v1", k), mlp_values[1], s.v1);
      check_real($sformatf("rb%0d_y", k), mlp_expected[0], s.y);
      repeat (SC + 1) @(posedge clk);
      @(negedge clk);
      check_real($sformatf("rb%0d_hold_v1", k), mlp_values[1], s.v1);
      check_real($sformatf("rb%0d_hold_y", k), mlp_expected[0], s.y);
    end
    finish_run();

    // Training, constant 0.5 prediction, converges in one epoch.
    run_q.push_back('{"conv", 1, 1, 2, NS, l_half});
    start_run(1'b0, 0.25, 0.7, 0);
    @(negedge clk);
    check_real("busy_lr", mlp_learning_rate, 0.25);
    check("busy_flag", busy, 1);
    finish_run();
    check("done_latency", done_cyc - start_cyc - 1, NS * (SC + 3) + 1);
    check_real("idle_lr", mlp_learning_rate, 0.0);

    // Training to the epoch limit with start and wr_en attempted mid-run.
    run_q.push_back('{"maxep", MAXE, 0, 2, NS * MAXE, l_half});
    start_run(1'b0, 0.5, 0.1, 0);
    repeat (10) @(negedge clk);
    wr_en = 1'b1; wr_addr = 2'd0; wr_values[0] = 0.75; wr_values[1] = 0.25; wr_expected[0] = 1.0;
    start = 1'b1; eval_only = 1'b1;
    @(posedge clk);
    #1 wr_en = 1'b0; start = 1'b0;
    check("midrun_busy", busy, 1);
    finish_run();

    // Eval with one wrong prediction; sample 0 must be unchanged by the ignored write.
    run_q.push_back('{"eval_miss", 1, 0, 3, 0, (3.0 * l_hit + l_miss) / 4.0});
    start_run(1'b1, 0.5, 10.0, 2);
    @(posedge clk);
    @(negedge clk);
    check_real("mem_kept_v0", mlp_values[0], 0.0);
    check_real("mem_kept_y", mlp_expected[0], 0.0);
    finish_run();

    // Reset while sample 1 is settling.
    start_run(1'b0, 0.5, 0.1, 0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    check_real("pre_rst_v1", mlp_values[1], 1.0);
    n = done_cnt;
    rst = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_training", mlp_training, 0);
    check_real("arst_v1", mlp_values[1], 0.0);
    check_real("arst_y", mlp_expected[0], 0.0);
    check_real("arst_lr", mlp_learning_rate, 0.0);
    check("arst_epoch_count", epoch_count, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    check("arst_no_done", done_cnt - n, 0);

    // Memory was cleared by the reset.
    run_q.push_back('{"post_rst", 1, 0, 4, 0, l_hit});
    start_run(1'b1, 0.5, 10.0, 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_real("cleared_v1", mlp_values[1], 0.0);
    check_real("cleared_y", mlp_expected[0], 0.0);
    finish_run();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the sequence itself stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
